obs_ctrl: RTL and testbench

Obstacle controller: the producer of the obstacle x-position (`i_xpos`) that the obstacle renderer consumes. It spawns an obstacle off the right edge of the screen after a pseudo-random gap and scrolls it left once per frame. On despawn it emits a score tick. On collision it freezes the obstacle until the game is disabled. It sits between the game-state logic and the obstacle renderer, and is clocked from the same pixel clock and counters.

---
 rtl/obs_ctrl.sv | 179 +++++++++++++++++
 tb/tb_obs_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obs_ctrl.sv
// obs_ctrl: spawns an obstacle off the right edge after a pseudo-random gap, scrolls it left once per frame,
// scores on despawn and freezes on collision. Optional macro OBS_SPEEDUP_EN adds a score-driven speed level.
module obs_ctrl #(
  parameter int unsigned CONV    = 0,
  parameter int unsigned MIN_GAP = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:CONV] i_hpos,
  input  logic [9:CONV] i_vpos,
  input  logic          i_game_en,
  input  logic          i_collide,
  input  logic [2:0]    i_speed,
  output logic [9:CONV] o_xpos,
  output logic          o_active,
  output logic          o_score_tick
);

  localparam int unsigned W        = 10 - CONV;
  localparam int unsigned SCREEN_W = 640 >> CONV;
  localparam int unsigned SPAWN_X  = SCREEN_W + 16;
  localparam int unsigned V_TICK   = 480 >> CONV;
  localparam int unsigned GAP_W    = 6;
  localparam int unsigned LFSR_W   = 8;
  localparam int unsigned STEP_W   = 4;

  localparam logic [W-1:0]      SPAWN_XW  = W'(SPAWN_X);
  localparam logic [W-1:0]      V_TICKW   = W'(V_TICK);
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W-1:0]       r_xpos;
  logic [W-1:0]       w_xpos_nxt;
  logic               r_active;
  logic               w_active_nxt;
  logic               r_score_tick;
  logic               w_score_nxt;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic [GAP_W-1:0]   w_gap_load;
  logic [LFSR_W-1:0]  r_lfsr;
  logic               w_lfsr_fb;
  logic               r_cond_q;
  logic               w_cond;
  logic               w_tick;
  logic [STEP_W-1:0]  w_step;
  logic [W-1:0]       w_step_w;

  // Frame tick: rising edge of the (row == V_TICK, col == 0) match, so one tick even when CONV repeats the pixel.
  assign w_cond = (i_vpos == V_TICKW) && (i_hpos == '0);
  assign w_tick = w_cond & ~r_cond_q;

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR; the nonzero seed keeps it out of the all-zero lock-up state.
  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_gap_load = GAP_W'(MIN_GAP) + GAP_W'(r_lfsr[4:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr   <= LFSR_SEED;
      r_cond_q <= 1'b0;
    end else begin
      r_lfsr   <= {r_lfsr[LFSR_W-2:0], w_lfsr_fb};
      r_cond_q <= w_cond;
    end
  end

`ifdef OBS_SPEEDUP_EN
  logic [2:0] r_level;
  logic [2:0] r_pass_cnt;
  logic [4:0] w_step_sum;

  assign w_step_sum = 5'(i_speed) + 5'(r_level) + 5'd1;
  assign w_step     = (w_step_sum > 5'd15) ? 4'd15 : w_step_sum[3:0];

  // Level rises once per eight obstacles passed; held clear while the game is idle.
  always_ff @(posedge clk) begin
    if (rst || (w_state_nxt == S_IDLE)) begin
      r_level    <= 3'd0;
      r_pass_cnt <= 3'd0;
    end else if (w_score_nxt) begin
      r_pass_cnt <= r_pass_cnt + 3'd1;
      if ((r_pass_cnt == 3'd7) && (r_level != 3'd7)) begin
        r_level <= r_level + 3'd1;
      end
    end
  end
`else
  assign w_step = STEP_W'(i_speed) + STEP_W'(1);
`endif

  assign w_step_w = W'(w_step);

  // Next-state and next-output logic; priority is game enable, then collision, then frame tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_xpos_nxt   = r_xpos;
    w_active_nxt = r_active;
    w_score_nxt  = 1'b0;
    w_gap_nxt    = r_gap;
    if (!i_game_en) begin
      w_state_nxt  = S_IDLE;
      w_xpos_nxt   = SPAWN_XW;
      w_active_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt  = S_GAP;
          w_gap_nxt    = w_gap_load;
          w_xpos_nxt   = SPAWN_XW;
          w_active_nxt = 1'b0;
        end
        S_GAP: begin
          if (i_collide) begin
            w_state_nxt = S_HALT;
          end else if (w_tick) begin
            w_gap_nxt = r_gap - GAP_W'(1);
            if (r_gap == GAP_W'(1)) begin
              w_state_nxt  = S_RUN;
              w_active_nxt = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i_collide) begin
            w_state_nxt = S_HALT;
          end else if (w_tick) begin
            // The guard keeps the subtraction from wrapping below zero.
            if (r_xpos <= w_step_w) begin
              w_state_nxt  = S_GAP;
              w_xpos_nxt   = SPAWN_XW;
              w_active_nxt = 1'b0;
              w_score_nxt  = 1'b1;
              w_gap_nxt    = w_gap_load;
            end else begin
              w_xpos_nxt = r_xpos - w_step_w;
            end
          end
        end
        S_HALT: begin
          w_state_nxt = S_HALT;
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_xpos_nxt   = SPAWN_XW;
          w_active_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_xpos       <= SPAWN_XW;
      r_active     <= 1'b0;
      r_score_tick <= 1'b0;
      r_gap        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_xpos       <= w_xpos_nxt;
      r_active     <= w_active_nxt;
      r_score_tick <= w_score_nxt;
      r_gap        <= w_gap_nxt;
    end
  end

  assign o_xpos       = r_xpos;
  assign o_active     = r_active;
  assign o_score_tick = r_score_tick;

endmodule

// File: tb/tb_obs_ctrl.sv
// Bench for obs_ctrl: CONV=0 and CONV=1 instances share stimulus; a behavioural model feeds a scoreboard queue.
`timescale 1ns/1ps
module tb_obs_ctrl;

  localparam int MIN_GAP = 20;
  localparam int S_IDLE = 0, S_GAP = 1, S_RUN = 2, S_HALT = 3;
`ifdef OBS_SPEEDUP_EN
  localparam int FINAL_STEP = 15;
`else
  localparam int FINAL_STEP = 8;
`endif

  typedef struct {
    int   inst;
    int   xpos;
    logic act;
    int   sc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos0, vpos0;
  logic [9:1] hpos1, vpos1;
  logic       game_en, collide;
  logic [2:0] speed;
  logic [9:0] xpos0;
  logic [9:1] xpos1;
  logic       act0, act1, sc0, sc1;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int   m_st[2];
  int   m_x[2];
  int   m_gap[2];
  int   m_passed[2];
  logic m_act[2];
  int   spawn_x[2] = '{656, 336};
  int   obs_score0;
  logic [7:0] m_lfsr;

  obs_ctrl #(.CONV(0), .MIN_GAP(MIN_GAP)) dut0 (
    .clk(clk), .rst(rst), .i_hpos(hpos0), .i_vpos(vpos0), .i_game_en(game_en),
    .i_collide(collide), .i_speed(speed), .o_xpos(xpos0), .o_active(act0), .o_score_tick(sc0)
  );

  obs_ctrl #(.CONV(1), .MIN_GAP(MIN_GAP)) dut1 (
    .clk(clk), .rst(rst), .i_hpos(hpos1), .i_vpos(vpos1), .i_game_en(game_en),
    .i_collide(collide), .i_speed(speed), .o_xpos(xpos1), .o_active(act1), .o_score_tick(sc1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_step(input int spd, input int passed);
    int lvl;
    int s;
    lvl = passed / 8;
    if (lvl > 7) lvl = 7;
`ifdef OBS_SPEEDUP_EN
    s = spd + lvl + 1;
    if (s > 15) s = 15;
`else
    s = spd + 1;
`endif
    return s;
  endfunction

  task automatic model_tick(input int i, input logic col, input logic [7:0] lf, output int sc);
    int st;
    sc = 0;
    if (col && (m_st[i] == S_GAP || m_st[i] == S_RUN)) begin
      m_st[i] = S_HALT;
    end else if (m_st[i] == S_GAP) begin
      if (m_gap[i] == 1) begin
        m_st[i]  = S_RUN;
        m_act[i] = 1'b1;
      end
      m_gap[i]--;
    end else if (m_st[i] == S_RUN) begin
      st = model_step(int'(speed), m_passed[i]);
      if (m_x[i] <= st) begin
        m_x[i]   = spawn_x[i];
        m_act[i] = 1'b0;
        m_gap[i] = MIN_GAP + int'(lf[4:0]);
        m_st[i]  = S_GAP;
        m_passed[i]++;
        sc = 1;
      end else begin
        m_x[i] = m_x[i] - st;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int fx0, input int fx1, input logic fa0, input logic fa1,
                       input int fs0, input int fs1, input int cnt0, input int cnt1);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.inst == 0) begin
        chk("xpos_c0", fx0, e.xpos);
        chk("active_c0", 32'(fa0), 32'(e.act));
        chk("score_lat_c0", fs0, e.sc);
        chk("score_cnt_c0", cnt0, e.sc);
      end else begin
        chk("xpos_c1", fx1, e.xpos);
        chk("active_c1", 32'(fa1), 32'(e.act));
        chk("score_lat_c1", fs1, e.sc);
        chk("score_cnt_c1", cnt1, e.sc);
      end
    end
  endtask

  // One compressed frame: tick row held two cycles (repeated pixel), then one off-row cycle.
  task automatic frame(input logic col);
    logic [7:0] lf;
    int   sc;
    exp_t e;
    int   fx0, fx1, fs0, fs1, cnt0, cnt1;
    logic fa0, fa1;
    vpos0 = 10'd480; hpos0 = '0; vpos1 = 9'd240; hpos1 = '0;
    collide = col;
    lf = m_lfsr;
    for (int i = 0; i < 2; i++) begin
      model_tick(i, col, lf, sc);
      e.inst = i; e.xpos = m_x[i]; e.act = m_act[i]; e.sc = sc;
      sb.push_back(e);
    end
    cyc(1);
    collide = 1'b0;
    fx0 = int'(xpos0); fx1 = int'(xpos1); fa0 = act0; fa1 = act1;
    fs0 = int'(sc0); fs1 = int'(sc1);
    cnt0 = fs0; cnt1 = fs1;
    cyc(1);
    vpos0 = '0; hpos0 = 10'd1; vpos1 = '0; hpos1 = 9'd1;
    cnt0 += int'(sc0); cnt1 += int'(sc1);
    cyc(1);
    cnt0 += int'(sc0); cnt1 += int'(sc1);
    obs_score0 += cnt0;
    drain(fx0, fx1, fa0, fa1, fs0, fs1, cnt0, cnt1);
  endtask

  task automatic game_on();
    game_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_GAP; m_gap[i] = MIN_GAP + int'(m_lfsr[4:0]);
      m_x[i] = spawn_x[i]; m_act[i] = 1'b0;
    end
    cyc(1);
  endtask

  initial begin
    int nf;
    int exp_gap;
    int a;
    rst = 1'b1; game_en = 1'b0; collide = 1'b0; speed = 3'd3;
    vpos0 = '0; hpos0 = 10'd1; vpos1 = '0; hpos1 = 9'd1;
    obs_score0 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_xpos_c0", 32'(xpos0), 656);
    chk("rst_xpos_c1", 32'(xpos1), 336);
    chk("rst_active", 32'(act0), 0);
    chk("rst_score", 32'(sc0), 0);
    chk("rst_lfsr", 32'(dut0.r_lfsr), 32'h0A5);
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_IDLE; m_x[i] = spawn_x[i]; m_act[i] = 1'b0; m_gap[i] = 0; m_passed[i] = 0;
    end
    cyc(2);

    // Spawn after the loaded gap, then scroll at step 4.
    exp_gap = MIN_GAP + int'(m_lfsr[4:0]);
    game_on();
    nf = 0;
    while (!act0 && nf < 80) begin
      frame(1'b0);
      nf++;
    end
    chk("spawn_frames", nf, exp_gap);
    chk("spawn_xpos", 32'(xpos0), 656);
    for (int k = 1; k <= 4; k++) begin
      frame(1'b0);
      chk("scroll_c0", 32'(xpos0), 32'(656 - 4 * k));
      chk("scroll_c1", 32'(xpos1), 32'(336 - 4 * k));
    end

    // Walk down to x=3 with step 4 pending, then despawn.
    speed = 3'd0;
    frame(1'b0);
    chk("speed_change", 32'(xpos0), 639);
    speed = 3'd7;
    nf = 0;
    while (m_x[0] > 7 && nf < 200) begin
      frame(1'b0);
      nf++;
    end
    chk("reach_7", 32'(xpos0), 7);
    speed = 3'd3;
    frame(1'b0);
    chk("reach_3", 32'(xpos0), 3);
    frame(1'b0);
    chk("despawn_xpos", 32'(xpos0), 656);
    chk("despawn_active", 32'(act0), 0);
    chk("despawn_score_total", obs_score0, 1);

    // Respawn and scroll to x=300, then collide on a tick.
    nf = 0;
    while (!(m_st[0] == S_RUN && m_x[0] == 300) && nf < 400) begin
      frame(1'b0);
      nf++;
    end
    chk("reach_300", 32'(xpos0), 300);
    frame(1'b1);
    chk("halt_xpos", 32'(xpos0), 300);
    for (int k = 0; k < 3; k++) begin
      frame(1'b0);
      chk("halt_hold", 32'(xpos0), 300);
      chk("halt_active", 32'(act0), 1);
    end
    game_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_IDLE; m_x[i] = spawn_x[i]; m_act[i] = 1'b0; m_passed[i] = 0;
    end
    cyc(1);
    chk("park_xpos_c0", 32'(xpos0), 656);
    chk("park_xpos_c1", 32'(xpos1), 336);
    chk("park_active", 32'(act0), 0);
    chk("park_score", 32'(sc0), 0);
    cyc(2);

    // Collision in IDLE is ignored; then pass 64 obstacles at speed 7.
    speed = 3'd7;
    collide = 1'b1;
    game_on();
    collide = 1'b0;
    obs_score0 = 0;
    nf = 0;
    while (obs_score0 < 64 && nf < 12000) begin
      frame(1'b0);
      nf++;
    end
    chk("passed_count", obs_score0, 64);
    nf = 0;
    while (!(m_st[0] == S_RUN && m_x[0] > 20) && nf < 200) begin
      frame(1'b0);
      nf++;
    end
    a = int'(xpos0);
    frame(1'b0);
    chk("final_step", 32'(a - int'(xpos0)), 32'(FINAL_STEP));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
